// File: rtl/cim_macro_arbiter_pkg.sv
// Shared types and lane geometry for the CIM S-box/key macro arbiter.
// Geometry is 16 byte lanes; each lane address is {DEMUX 3b, RWL 6b}.
package cim_arb_pkg;

  localparam int LANES       = 16;
  localparam int DMX_W       = 3;
  localparam int RWL_W       = 6;
  localparam int RIO_W       = 8;
  localparam int LANE_ADDR_W = DMX_W + RWL_W;
  localparam int ADDR_W      = LANES * LANE_ADDR_W;
  localparam int DATA_W      = LANES * RIO_W;

  typedef enum logic {
    OP_LOOKUP = 1'b0,
    OP_ARK    = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/cim_macro_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Returns the first requester at or after ptr as both a one-hot grant and an index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  function automatic int wrap_idx(input int p, input int off);
    return (p + off) % N;
  endfunction

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int off = 0; off < N; off++) begin
      if (!any && req[wrap_idx(int'(ptr), off)]) begin
        any                        = 1'b1;
        gnt[wrap_idx(int'(ptr), off)] = 1'b1;
        idx                        = IW'(wrap_idx(int'(ptr), off));
      end
    end
  end

endmodule

// File: rtl/cim_macro_arbiter.sv
// Round-robin, transaction-locked arbiter sharing one CIM S-box/key macro between
// N_CLI requesters; owns macro pin sequencing and RIO capture.
module cim_macro_arbiter
  import cim_arb_pkg::*;
#(
  parameter int N_CLI     = 2,
  parameter int ARK_BEATS = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic [N_CLI-1:0]          req_i,
  input  logic [N_CLI-1:0]          op_i,
  input  logic [N_CLI*ADDR_W-1:0]   addr_i,
  input  logic [N_CLI*LANES-1:0]    bits_i,
  output logic [N_CLI-1:0]          gnt_o,
  output logic [2:0]                beat_o,
  output logic [N_CLI-1:0]          rvld_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      busy_o,
  output logic [LANES*DMX_W-1:0]    DEMUX_ADD,
  output logic [LANES*RWL_W-1:0]    RWL_DEC_ADD,
  output logic [LANES-1:0]          IN,
  input  logic [DATA_W-1:0]         RIO
);

  localparam int IW     = (N_CLI > 1) ? $clog2(N_CLI) : 1;
  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [2:0]          beat_q, beat_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [N_CLI-1:0]    arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LANES-1:0]    sel_bits;

  rr_arbiter #(.N(N_CLI), .IW(IW)) u_rr (
    .req (req_i),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOOKUP;
      owner_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d = ST_ISSUE;
          owner_d = arb_idx;
          op_d    = (|(arb_gnt & op_i)) ? OP_ARK : OP_LOOKUP;
          rr_d    = (arb_idx == IW'(N_CLI - 1)) ? '0 : arb_idx + IW'(1);
          beat_d  = '0;
        end
      end
      ST_ISSUE: begin
        if (op_q == OP_LOOKUP || beat_q == 3'(ARK_BEATS - 1)) begin
          state_d = ST_WAIT;
          wait_d  = '0;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end
      ST_WAIT: begin
        // RIO is only valid on the final wait cycle, so capture exactly there.
        if (wait_q == WAIT_W'(RD_LAT - 1)) begin
          state_d = ST_RESP;
          rdata_d = RIO;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_o       = '0;
    rvld_o      = '0;
    beat_o      = '0;
    DEMUX_ADD   = '0;
    RWL_DEC_ADD = '0;
    IN          = '0;
    sel_addr    = '0;
    sel_bits    = '0;
    for (int c = 0; c < N_CLI; c++) begin
      if (owner_q == IW'(c)) begin
        sel_addr = addr_i[c*ADDR_W +: ADDR_W];
        sel_bits = bits_i[c*LANES +: LANES];
      end
    end
    // Pins carry owner data only during ISSUE; every other state parks them at 0.
    if (state_q == ST_ISSUE) begin
      gnt_o[owner_q] = 1'b1;
      for (int j = 0; j < LANES; j++) begin
        DEMUX_ADD[j*DMX_W +: DMX_W]   = sel_addr[j*LANE_ADDR_W + RWL_W +: DMX_W];
        RWL_DEC_ADD[j*RWL_W +: RWL_W] = sel_addr[j*LANE_ADDR_W +: RWL_W];
      end
      if (op_q == OP_ARK) begin
        IN     = sel_bits;
        beat_o = beat_q;
      end
    end
    if (state_q == ST_RESP) begin
      rvld_o[owner_q] = 1'b1;
    end
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_cim_macro_arbiter.sv
// Scoreboard bench for cim_macro_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level model of grant order and timing.
module tb_cim_macro_arbiter;
  import cim_arb_pkg::*;

  localparam int N_CLI     = 2;
  localparam int ARK_BEATS = 8;
  localparam int RD_LAT    = 1;

  logic                    CLK = 1'b0;
  logic                    RSTn = 1'b0;
  logic [N_CLI-1:0]        req_i = '0;
  logic [N_CLI-1:0]        op_i = '0;
  logic [N_CLI*ADDR_W-1:0] addr_i = '0;
  logic [N_CLI*LANES-1:0]  bits_i = '0;
  logic [DATA_W-1:0]       RIO = '0;
  logic [N_CLI-1:0]        gnt_o;
  logic [2:0]              beat_o;
  logic [N_CLI-1:0]        rvld_o;
  logic [DATA_W-1:0]       rdata_o;
  logic                    busy_o;
  logic [LANES*DMX_W-1:0]  DEMUX_ADD;
  logic [LANES*RWL_W-1:0]  RWL_DEC_ADD;
  logic [LANES-1:0]        IN;

  cim_macro_arbiter #(.N_CLI(N_CLI), .ARK_BEATS(ARK_BEATS), .RD_LAT(RD_LAT)) dut (
    .CLK(CLK), .RSTn(RSTn), .req_i(req_i), .op_i(op_i), .addr_i(addr_i),
    .bits_i(bits_i), .gnt_o(gnt_o), .beat_o(beat_o), .rvld_o(rvld_o),
    .rdata_o(rdata_o), .busy_o(busy_o), .DEMUX_ADD(DEMUX_ADD),
    .RWL_DEC_ADD(RWL_DEC_ADD), .IN(IN), .RIO(RIO)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int nchk = 0;
  int nfail = 0;

  typedef struct {
    int own;
    int rcyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  // Transaction-level model: one active transaction with its arbitration cycle,
  // length in grant cycles and response cycle; everything else follows from those.
  bit               rst_seen = 1'b0;
  bit               act = 1'b0;
  bit               idle_now;
  bit               t_ark;
  int               t_own, t_s, t_len, t_r, rr = 0;
  logic [DATA_W-1:0] exp_rdata = '0;
  logic [ADDR_W-1:0] own_addr;
  logic [8:0]        a9;
  logic [LANES*DMX_W-1:0] exp_dmx;
  logic [LANES*RWL_W-1:0] exp_rwl;
  logic [LANES-1:0]  exp_in;
  bit               ing, bz;

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] want);
    nchk++;
    if (got !== want) begin
      nfail++;
      $display("[TB] FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  // Monitor: compares every cycle against the model, then advances the model
  // for the clock edge that ends this cycle.
  always @(negedge CLK) begin
    if (rst_seen) begin
      ing = act && (cyc > t_s) && (cyc <= t_s + t_len);
      bz  = act && (cyc > t_s) && (cyc <= t_r);
      exp_dmx = '0;
      exp_rwl = '0;
      exp_in  = '0;
      if (ing) begin
        own_addr = addr_i[t_own*ADDR_W +: ADDR_W];
        for (int l = 0; l < LANES; l++) begin
          a9 = own_addr[ADDR_W-1-9*l -: 9];
          exp_dmx[LANES*DMX_W-1-3*l -: 3] = a9[8:6];
          exp_rwl[LANES*RWL_W-1-6*l -: 6] = a9[5:0];
        end
        if (t_ark) exp_in = bits_i[t_own*LANES +: LANES];
      end
      checkOutput("gnt", gnt_o, ing ? (1 << t_own) : 0);
      checkOutput("beat", beat_o, (ing && t_ark) ? (cyc - t_s - 1) : 0);
      checkOutput("busy", busy_o, bz);
      checkOutput("demux", DEMUX_ADD, exp_dmx);
      checkOutput("rwl", RWL_DEC_ADD, exp_rwl);
      checkOutput("in", IN, exp_in);
      checkOutput("rdata", rdata_o, exp_rdata);
      if (rvld_o != '0 || (sb.size() > 0 && sb[0].rcyc == cyc)) begin
        if (sb.size() == 0) begin
          checkOutput("rvld_spurious", rvld_o, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("rvld_cycle", cyc, e.rcyc);
          checkOutput("rvld_owner", rvld_o, 1 << e.own);
        end
      end
    end
    if (!RSTn) begin
      act       = 1'b0;
      rr        = 0;
      exp_rdata = '0;
      sb.delete();
      rst_seen  = 1'b1;
    end else if (rst_seen) begin
      idle_now = !act;
      if (act && cyc == t_s + t_len + RD_LAT) exp_rdata = RIO;
      if (act && cyc == t_r) act = 1'b0;
      if (idle_now && req_i != '0) begin
        for (int off = 0; off < N_CLI; off++) begin
          if (!act && req_i[(rr + off) % N_CLI]) begin
            t_own = (rr + off) % N_CLI;
            act   = 1'b1;
          end
        end
        t_ark = op_i[t_own];
        t_s   = cyc;
        t_len = t_ark ? ARK_BEATS : 1;
        t_r   = t_s + t_len + RD_LAT + 1;
        rr    = (t_own + 1) % N_CLI;
        sb.push_back('{own: t_own, rcyc: t_r});
      end
    end
  end

  task automatic applyStimulus(input int c, input bit ark, input logic [8:0] lane_addr,
                               input logic [15:0] bits);
    for (int l = 0; l < LANES; l++) addr_i[c*ADDR_W + l*9 +: 9] = lane_addr;
    bits_i[c*LANES +: LANES] = bits;
    op_i[c]  = ark;
    req_i[c] = 1'b1;
  endtask

  task automatic waitGnt(input int c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if (gnt_o[c]) ok = 1'b1;
    end
    checkOutput("gnt_timeout", ok, 1);
  endtask

  task automatic waitRvld(input int c, output int when);
    bit ok;
    ok   = 1'b0;
    when = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if (rvld_o[c]) begin
        ok   = 1'b1;
        when = cyc;
      end
    end
    checkOutput("rvld_timeout", ok, 1);
  endtask

  // Requests one transaction, drops req right after the first grant cycle and
  // returns the request-to-rvld latency in cycles.
  task automatic requestTxn(input int c, input bit ark, input logic [8:0] lane_addr,
                            input logic [15:0] bits, output int lat);
    int start, when;
    bit ok;
    @(posedge CLK);
    #1;
    applyStimulus(c, ark, lane_addr, bits);
    start = cyc;
    waitGnt(c, ok);
    @(posedge CLK);
    #1;
    req_i[c] = 1'b0;
    waitRvld(c, when);
    lat = when - start;
  endtask

  initial begin
    int lat;
    bit ok;
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    bit ok;
    $display("[TB] reset");
    repeat (3) @(posedge CLK);
    #1;
    RSTn = 1'b1;
    repeat (2) @(posedge CLK);

    $display("[TB] LOOKUP, client 0, S-box output 0xFB on all lanes");
    RIO = {16{8'hFB}};
    requestTxn(0, 1'b0, 9'h063, 16'h0000, lat);
    checkOutput("t1_latency", lat, 2 + RD_LAT);
    checkOutput("t1_rdata", rdata_o, {16{8'hFB}});

    $display("[TB] ARK, client 1, bits A5A5");
    RIO = {4{32'h0123_4567}};
    requestTxn(1, 1'b1, 9'h1AB, 16'hA5A5, lat);
    checkOutput("t2_latency", lat, 1 + ARK_BEATS + RD_LAT);

    $display("[TB] ARK, client 0, req dropped during ISSUE");
    RIO = {4{32'hDEAD_BEEF}};
    requestTxn(0, 1'b1, 9'h0F1, 16'h3C3C, lat);
    checkOutput("t5_latency", lat, 1 + ARK_BEATS + RD_LAT);
    RIO = {4{32'h5555_AAAA}};
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("t5_rdata_hold", rdata_o, {4{32'hDEAD_BEEF}});

    $display("[TB] both clients request LOOKUP continuously");
    applyStimulus(0, 1'b0, 9'h011, 16'h0);
    applyStimulus(1, 1'b0, 9'h122, 16'h0);
    repeat (20) @(posedge CLK);
    #1;
    req_i = '0;
    repeat (8) @(posedge CLK);

    $display("[TB] reset at ARK beat 4");
    #1;
    applyStimulus(1, 1'b1, 9'h077, 16'hF00F);
    waitGnt(1, ok);
    repeat (4) @(posedge CLK);
    #1;
    RSTn     = 1'b0;
    req_i[1] = 1'b0;
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    @(negedge CLK);
    checkOutput("t4_busy", busy_o, 0);
    checkOutput("t4_gnt", gnt_o, 0);
    checkOutput("t4_beat", beat_o, 0);
    requestTxn(1, 1'b0, 9'h155, 16'h0, lat);
    checkOutput("t4_latency", lat, 2 + RD_LAT);

    $display("[TB] random traffic");
    for (int k = 0; k < 3000; k++) begin
      @(posedge CLK);
      #1;
      RSTn = ($urandom_range(0, 199) != 0);
      for (int c = 0; c < N_CLI; c++) begin
        if (!req_i[c]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_i[c] = 1'b1;
            op_i[c]  = 1'($urandom_range(0, 1));
          end
        end else begin
          if ($urandom_range(0, 7) == 0) req_i[c] = 1'b0;
          if ($urandom_range(0, 9) == 0) op_i[c] = ~op_i[c];
        end
      end
      for (int b = 0; b < N_CLI*ADDR_W; b++) addr_i[b] = 1'($urandom_range(0, 1));
      bits_i = (N_CLI*LANES)'($urandom);
      RIO    = {$urandom, $urandom, $urandom, $urandom};
    end
    @(posedge CLK);
    #1;
    RSTn  = 1'b1;
    req_i = '0;
    repeat (30) @(posedge CLK);
    @(negedge CLK);
    checkOutput("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
